// File: rtl/sim_harness_pkg.sv
// Shared state encoding and defaults for the simulation run controller.
// Pure declarations: no logic, no latency, no flow control.
package sim_harness_pkg;

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_RUN        = 2'd1,
      ST_DONE       = 2'd2,
      ST_TIMEOUT    = 2'd3
   } state_t;

   localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sticky_verdict.sv
// Per-channel done/fail latch: first qualified done captures the verdict once.
// Registered outputs one cycle after capture; next-state values exposed combinationally; no backpressure.
module sticky_verdict (
   input  logic clk,
   input  logic rst,
   input  logic capture,
   input  logic done,
   input  logic pass,
   output logic done_q,
   output logic fail_q,
   output logic done_d,
   output logic fail_d
);

   always_comb begin
      done_d = done_q;
      fail_d = fail_q;
      if (capture && done && !done_q) begin
         done_d = 1'b1;
         fail_d = !pass;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         done_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         done_q <= done_d;
         fail_q <= fail_d;
      end
   end

endmodule

// File: rtl/sim_harness_ctrl.sv
// Run controller: DUT reset sequencing, RUN cycle counter with watchdog, per-channel verdict collection.
// All outputs registered (one edge after the deciding condition); status-only, no backpressure.
module sim_harness_ctrl
   import sim_harness_pkg::*;
#(
   parameter int N_CH           = 3,
   parameter int RST_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 32
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic [N_CH-1:0]   in_ch_en,
   input  logic [N_CH-1:0]   in_done,
   input  logic [N_CH-1:0]   in_pass,
   output logic              out_dut_rst,
   output logic [1:0]        out_state,
   output logic [CNT_W-1:0]  out_cycle,
   output logic [N_CH-1:0]   out_done_mask,
   output logic [N_CH-1:0]   out_fail_mask,
   output logic              out_finish,
   output logic              out_all_pass
);

   localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        hold_q, hold_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [N_CH-1:0]   en_q;
   logic [N_CH-1:0]   done_q, done_d, fail_q, fail_d;
   logic              run;
   logic              all_done;

   assign run = (state_q == ST_RUN);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sticky_verdict u_verdict (
         .clk     (in_clk),
         .rst     (in_rst),
         .capture (run && en_q[i]),
         .done    (in_done[i]),
         .pass    (in_pass[i]),
         .done_q  (done_q[i]),
         .fail_q  (fail_q[i]),
         .done_d  (done_d[i]),
         .fail_d  (fail_d[i])
      );
   end

   // Bits latched this cycle count toward completion, so DONE wins over a coincident timeout.
   assign all_done = &(done_d | ~en_q);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cyc_d   = cyc_q;
      case (state_q)
         ST_RESET_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = ST_RUN;
            else                     hold_d  = hold_q + 8'd1;
         end
         ST_RUN: begin
            if (all_done)                state_d = ST_DONE;
            else if (cyc_q == CYC_LAST)  state_d = ST_TIMEOUT;
            else                         cyc_d   = cyc_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_q      <= ST_RESET_HOLD;
         hold_q       <= 8'd0;
         cyc_q        <= '0;
         en_q         <= in_ch_en;
         out_dut_rst  <= 1'b1;
         out_finish   <= 1'b0;
         out_all_pass <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cyc_q        <= cyc_d;
         out_dut_rst  <= (state_d == ST_RESET_HOLD);
         out_finish   <= (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
         out_all_pass <= (state_d == ST_DONE) && (fail_d == '0);
      end
   end

   assign out_state     = state_q;
   assign out_cycle     = cyc_q;
   assign out_done_mask = done_q;
   assign out_fail_mask = fail_q;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Scoreboard bench for sim_harness_ctrl: stimulus pushes expected post-edge outputs, monitor pops and compares.
module tb_sim_harness_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  ch_en, done, pass;
   logic        dut_rst, finish, all_pass;
   logic [1:0]  state;
   logic [31:0] cycle;
   logic [2:0]  dmask, fmask;

   always #5 clk = ~clk;

   sim_harness_ctrl #(
      .N_CH(3), .RST_CYCLES(2), .TIMEOUT_CYCLES(20), .CNT_W(32)
   ) dut (
      .in_clk        (clk),
      .in_rst        (rst),
      .in_ch_en      (ch_en),
      .in_done       (done),
      .in_pass       (pass),
      .out_dut_rst   (dut_rst),
      .out_state     (state),
      .out_cycle     (cycle),
      .out_done_mask (dmask),
      .out_fail_mask (fmask),
      .out_finish    (finish),
      .out_all_pass  (all_pass)
   );

   typedef struct {
      int          due;
      int          cid;
      int          k;
      logic [1:0]  st;
      logic [31:0] cy;
      logic [2:0]  dm;
      logic [2:0]  fm;
      logic        dr;
      logic        fin;
      logic        ap;
   } exp_t;

   exp_t q[$];
   int   tb_cyc    = 0;
   int   checks    = 0;
   int   failures  = 0;
   bit   stim_done = 1'b0;

   // Expected outputs as seen just after the next rising edge.
   task automatic expect_nx(input int cid, input int k, input logic [1:0] st, input int cy,
                            input logic [2:0] dm, input logic [2:0] fm,
                            input logic dr, input logic fin, input logic ap);
      exp_t e;
      e.due = tb_cyc + 1;
      e.cid = cid;
      e.k   = k;
      e.st  = st;
      e.cy  = 32'(cy);
      e.dm  = dm;
      e.fm  = fm;
      e.dr  = dr;
      e.fin = fin;
      e.ap  = ap;
      q.push_back(e);
   endtask

   // Reset edge, then the two hold cycles; leaves the bench at the start of RUN cycle 0.
   task automatic do_reset(input int cid, input logic [2:0] en, input logic [2:0] hold_done);
      rst   = 1'b0;
      ch_en = en;
      done  = hold_done;
      pass  = 3'b000;
      expect_nx(cid, -3, 2'd0, 0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      expect_nx(cid, -2, 2'd0, 0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      expect_nx(cid, -1, 2'd1, 0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
   endtask

   // a0..a2: RUN cycle at which done rises (level, held), -1 = never.
   // pass_at: pass bit on the arrival cycle; pass is 1 on every other cycle.
   task automatic run_case(input int cid, input logic [2:0] en, input int a0, input int a1, input int a2,
                           input logic [2:0] pass_at, input int ncyc, input int end_cyc, input int rst_at,
                           input logic [1:0] st_end, input logic [2:0] dm_end, input logic [2:0] fm_end,
                           input logic ap_end);
      int         a[3];
      logic [2:0] arr;
      a[0] = a0;
      a[1] = a1;
      a[2] = a2;
      ch_en = ~en;
      for (int k = 0; k < ncyc; k++) begin
         if (k == rst_at) begin
            rst   = 1'b0;
            ch_en = en;
            expect_nx(cid, k, 2'd0, 0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            return;
         end
         arr = 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (a[i] >= 0 && k >= a[i]) arr[i] = 1'b1;
            pass[i] = (k == a[i]) ? pass_at[i] : 1'b1;
         end
         done = arr;
         if (k < end_cyc)
            expect_nx(cid, k, 2'd1, k + 1, arr & en, arr & en & ~pass_at, 1'b0, 1'b0, 1'b0);
         else
            expect_nx(cid, k, st_end, end_cyc, dm_end, fm_end, 1'b0, 1'b1, ap_end);
         @(negedge clk);
      end
   endtask

   initial begin : stimulus
      rst   = 1'b0;
      ch_en = 3'b111;
      done  = 3'b000;
      pass  = 3'b000;
      // all pass, last done at cycle 7
      do_reset(1, 3'b111, 3'b000);
      run_case(1, 3'b111, 3, 7, 5, 3'b111, 10, 7, -1, 2'd2, 3'b111, 3'b000, 1'b1);
      // channel 1 fails at its done cycle, pass toggles later
      do_reset(2, 3'b111, 3'b000);
      run_case(2, 3'b111, 3, 7, 5, 3'b101, 10, 7, -1, 2'd2, 3'b111, 3'b010, 1'b0);
      // channel 2 never done: watchdog
      do_reset(3, 3'b111, 3'b000);
      run_case(3, 3'b111, 3, 6, -1, 3'b111, 22, 19, -1, 2'd3, 3'b011, 3'b000, 1'b0);
      // last done on the timeout cycle; done pulses during hold ignored
      do_reset(4, 3'b111, 3'b111);
      run_case(4, 3'b111, 3, 19, 5, 3'b111, 21, 19, -1, 2'd2, 3'b111, 3'b000, 1'b1);
      // channel 1 disabled (and failing); in_ch_en changed after reset is ignored
      do_reset(5, 3'b101, 3'b111);
      run_case(5, 3'b101, 4, 2, 6, 3'b101, 9, 6, -1, 2'd2, 3'b101, 3'b000, 1'b1);
      // no channels enabled: DONE after one RUN cycle
      do_reset(6, 3'b000, 3'b000);
      run_case(6, 3'b000, 1, 2, 3, 3'b000, 4, 0, -1, 2'd2, 3'b000, 3'b000, 1'b1);
      // reset asserted at RUN cycle 10 clears masks
      do_reset(7, 3'b111, 3'b000);
      run_case(7, 3'b111, 3, -1, 5, 3'b110, 12, 99, 10, 2'd1, 3'b000, 3'b000, 1'b0);
      do_reset(8, 3'b111, 3'b000);
      stim_done = 1'b1;
   end

   initial begin : monitor
      exp_t e;
      int   idle;
      idle = 0;
      while (1) begin
         @(posedge clk);
         tb_cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= tb_cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due < tb_cyc) begin
               failures++;
               $display("FAIL case%0d k%0d late: due=%0d now=%0d", e.cid, e.k, e.due, tb_cyc);
            end else if (state !== e.st || cycle !== e.cy || dmask !== e.dm || fmask !== e.fm ||
                         dut_rst !== e.dr || finish !== e.fin || all_pass !== e.ap) begin
               failures++;
               $display("FAIL case%0d k%0d: got st=%0d cyc=%0d dm=%b fm=%b rst=%b fin=%b ap=%b, want st=%0d cyc=%0d dm=%b fm=%b rst=%b fin=%b ap=%b",
                        e.cid, e.k, state, cycle, dmask, fmask, dut_rst, finish, all_pass,
                        e.st, e.cy, e.dm, e.fm, e.dr, e.fin, e.ap);
            end
         end
         if (stim_done) begin
            idle++;
            if (q.size() == 0 || idle > 10) break;
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
